// File: rtl/dmem_bus_pkg.sv
// Shared types and defaults for the data-side bus bridge.
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REG_DMEM,
    REG_MMIO,
    REG_NONE
  } region_t;

  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1002_0000;
  localparam int unsigned WAIT_CNT_W        = 4;

endpackage

// File: rtl/mmio_regfile.sv
// Bank of memory-mapped output registers with one write port and a read mux.
module mmio_regfile #(
  parameter  int N_REGS = 3,
  parameter  int REG_W  = 8,
  localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_widx,
  input  logic [REG_W-1:0]        i_wdata,
  input  logic [IDX_W-1:0]        i_ridx,
  output logic [REG_W-1:0]        o_rdata,
  output logic [N_REGS*REG_W-1:0] o_regs
);

  logic [REG_W-1:0] r_regs [N_REGS];

  // Registers clear on reset; an in-range write updates one register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < N_REGS; k++) r_regs[k] <= '0;
    end else if (i_we && (32'(i_widx) < N_REGS)) begin
      r_regs[i_widx] <= i_wdata;
    end
  end

  // Read mux; out-of-range indices read as zero.
  always_comb begin
    o_rdata = '0;
    if (32'(i_ridx) < N_REGS) o_rdata = r_regs[i_ridx];
  end

  // Flatten the bank onto the display output bus.
  always_comb begin
    o_regs = '0;
    for (int k = 0; k < N_REGS; k++) o_regs[k*REG_W +: REG_W] = r_regs[k];
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// CPU data-port bridge: decodes DMEM/MMIO regions, sequences DMEM accesses
// with optional wait states, stalls the core until done, flags unmapped hits.
module dmem_bus_bridge
  import dmem_bus_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
  parameter int          DMEM_DEPTH  = 2048,
  parameter logic [31:0] MMIO_BASE   = DEFAULT_MMIO_BASE,
  parameter int          N_MMIO      = 3,
  parameter int          MMIO_W      = 8,
  parameter int          WAIT_CYCLES = 0,
  localparam int         ADDR_W      = $clog2(DMEM_DEPTH),
  localparam int         IDX_W       = (N_MMIO > 1) ? $clog2(N_MMIO) : 1
) (
  input  logic                     i_clk_in,
  input  logic                     i_reset,
  input  logic                     i_cpu_ena,
  input  logic                     i_cpu_r,
  input  logic                     i_cpu_w,
  input  logic [31:0]              i_cpu_addr,
  input  logic [31:0]              i_cpu_wdata,
  input  logic [3:0]               i_cpu_be,
  output logic [31:0]              o_cpu_rdata,
  output logic                     o_cpu_stall,
  output logic                     o_bus_err,
  output logic                     o_mem_ena,
  output logic                     o_mem_w,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  output logic [3:0]               o_mem_be,
  input  logic [31:0]              i_mem_rdata,
  output logic [N_MMIO*MMIO_W-1:0] o_mmio_out
);

  localparam logic [32:0] DMEM_BYTES = 33'(DMEM_DEPTH) * 33'd4;
  localparam logic [32:0] MMIO_BYTES = 33'(N_MMIO) * 33'd4;

  state_t                r_state;
  state_t                w_nextState;
  region_t               r_region;
  region_t               w_region;
  logic                  r_isWrite;
  logic [ADDR_W-1:0]     r_memIdx;
  logic [IDX_W-1:0]      r_mmioIdx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [WAIT_CNT_W-1:0] r_waitCnt;

  logic                  w_req;
  logic [31:0]           w_dmemOff;
  logic [31:0]           w_mmioOff;
  logic                  w_mmioWe;
  logic [MMIO_W-1:0]     w_mmioRdata;

  assign w_req     = i_cpu_ena & (i_cpu_r | i_cpu_w);
  assign w_dmemOff = i_cpu_addr - DATA_BASE;
  assign w_mmioOff = i_cpu_addr - MMIO_BASE;
  assign w_mmioWe  = (r_state == ST_IDLE) & w_req & (w_region == REG_MMIO)
                     & i_cpu_w & i_cpu_be[0];

  // Region decode; offsets below a base wrap to large values and fall outside.
  always_comb begin
    w_region = REG_NONE;
    if ({1'b0, w_dmemOff} < DMEM_BYTES)      w_region = REG_DMEM;
    else if ({1'b0, w_mmioOff} < MMIO_BYTES) w_region = REG_MMIO;
  end

  // State register.
  always_ff @(posedge i_clk_in) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic; DONE always returns to IDLE so a held request restarts there.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_req) w_nextState = (w_region == REG_DMEM) ? ST_ACCESS : ST_DONE;
      ST_ACCESS: w_nextState = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT:   if (r_waitCnt == '0) w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Capture the request when accepted so it completes even if the core drops it.
  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_region  <= REG_NONE;
      r_isWrite <= 1'b0;
      r_memIdx  <= '0;
      r_mmioIdx <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_region  <= w_region;
      r_isWrite <= i_cpu_w;
      r_memIdx  <= w_dmemOff[ADDR_W+1:2];
      r_mmioIdx <= w_mmioOff[IDX_W+1:2];
      r_wdata   <= i_cpu_wdata;
      r_be      <= i_cpu_be;
    end
  end

  // Wait-state counter, loaded as the DMEM access cycle ends.
  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_waitCnt <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_waitCnt <= (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;
    end else if ((r_state == ST_WAIT) && (r_waitCnt != '0)) begin
      r_waitCnt <= r_waitCnt - 1'b1;
    end
  end

  mmio_regfile #(
    .N_REGS (N_MMIO),
    .REG_W  (MMIO_W)
  ) u_mmio (
    .i_clk   (i_clk_in),
    .i_reset (i_reset),
    .i_we    (w_mmioWe),
    .i_widx  (w_mmioOff[IDX_W+1:2]),
    .i_wdata (i_cpu_wdata[MMIO_W-1:0]),
    .i_ridx  (r_mmioIdx),
    .o_rdata (w_mmioRdata),
    .o_regs  (o_mmio_out)
  );

  // Core-side and DMEM-side outputs; reset blocks any DMEM commit on its edge.
  always_comb begin
    o_cpu_stall = ((r_state != ST_IDLE) && (r_state != ST_DONE))
                  || ((r_state == ST_IDLE) && w_req);
    o_mem_ena   = (r_state == ST_ACCESS) && !i_reset;
    o_mem_w     = o_mem_ena && r_isWrite;
    o_mem_addr  = r_memIdx;
    o_mem_wdata = r_wdata;
    o_mem_be    = r_be;
    o_bus_err   = (r_state == ST_DONE) && (r_region == REG_NONE);
    o_cpu_rdata = '0;
    if ((r_state == ST_DONE) && !r_isWrite) begin
      if (r_region == REG_DMEM)      o_cpu_rdata = i_mem_rdata;
      else if (r_region == REG_MMIO) o_cpu_rdata = 32'(w_mmioRdata);
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench: two bridges (0 and 3 wait states), each with its own DMEM model.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuEna   [2];
  logic        cpuR     [2];
  logic        cpuW     [2];
  logic [31:0] cpuAddr  [2];
  logic [31:0] cpuWdata [2];
  logic [3:0]  cpuBe    [2];
  logic [31:0] cpuRdata [2];
  logic        cpuStall [2];
  logic        busErr   [2];
  logic        memEna   [2];
  logic        memW     [2];
  logic [10:0] memAddr  [2];
  logic [31:0] memWdata [2];
  logic [3:0]  memBe    [2];
  logic [31:0] memRdata [2];
  logic [23:0] mmioOut  [2];
  logic [31:0] ram      [2][2048];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.WAIT_CYCLES(0)) dut0 (
    .i_clk_in(clk), .i_reset(reset), .i_cpu_ena(cpuEna[0]), .i_cpu_r(cpuR[0]),
    .i_cpu_w(cpuW[0]), .i_cpu_addr(cpuAddr[0]), .i_cpu_wdata(cpuWdata[0]),
    .i_cpu_be(cpuBe[0]), .o_cpu_rdata(cpuRdata[0]), .o_cpu_stall(cpuStall[0]),
    .o_bus_err(busErr[0]), .o_mem_ena(memEna[0]), .o_mem_w(memW[0]),
    .o_mem_addr(memAddr[0]), .o_mem_wdata(memWdata[0]), .o_mem_be(memBe[0]),
    .i_mem_rdata(memRdata[0]), .o_mmio_out(mmioOut[0])
  );

  dmem_bus_bridge #(.WAIT_CYCLES(3)) dut1 (
    .i_clk_in(clk), .i_reset(reset), .i_cpu_ena(cpuEna[1]), .i_cpu_r(cpuR[1]),
    .i_cpu_w(cpuW[1]), .i_cpu_addr(cpuAddr[1]), .i_cpu_wdata(cpuWdata[1]),
    .i_cpu_be(cpuBe[1]), .o_cpu_rdata(cpuRdata[1]), .o_cpu_stall(cpuStall[1]),
    .o_bus_err(busErr[1]), .o_mem_ena(memEna[1]), .o_mem_w(memW[1]),
    .o_mem_addr(memAddr[1]), .o_mem_wdata(memWdata[1]), .o_mem_be(memBe[1]),
    .i_mem_rdata(memRdata[1]), .o_mmio_out(mmioOut[1])
  );

  // Synchronous-read DMEM models with byte-enabled writes; read data holds when idle.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (memEna[k]) begin
        if (memW[k]) begin
          for (int b = 0; b < 4; b++)
            if (memBe[k][b]) ram[k][memAddr[k]][b*8 +: 8] <= memWdata[k][b*8 +: 8];
        end
        memRdata[k] <= ram[k][memAddr[k]];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic dropRequest(input int sel);
    cpuEna[sel] = 1'b0;
    cpuR[sel]   = 1'b0;
    cpuW[sel]   = 1'b0;
  endtask

  // One complete access: counts stall and mem_ena cycles, captures DONE outputs.
  task automatic applyStimulus(input int sel, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] b, output int stalls,
                               output logic [31:0] rdata, output logic err,
                               output int enaCycles, output logic [10:0] lastAddr,
                               output int errCycles);
    bit done = 0;
    stalls = 0; enaCycles = 0; errCycles = 0; rdata = '0; err = 0; lastAddr = '0;
    @(posedge clk); #1;
    cpuEna[sel] = 1'b1; cpuR[sel] = r; cpuW[sel] = w;
    cpuAddr[sel] = a; cpuWdata[sel] = wd; cpuBe[sel] = b;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (memEna[sel]) begin
        enaCycles++;
        lastAddr = memAddr[sel];
      end
      if (busErr[sel]) errCycles++;
      if (cpuStall[sel]) begin
        stalls++;
      end else begin
        rdata = cpuRdata[sel];
        err   = busErr[sel];
        done  = 1;
      end
      @(posedge clk); #1;
      if (done) dropRequest(sel);
    end
    if (!done) begin
      checkOutput("access_timeout", 32'd1, 32'd0);
      dropRequest(sel);
    end
  endtask

  initial begin
    int          st, en, ec;
    logic [31:0] rd;
    logic        er;
    logic [10:0] ad;
    logic [5:0]  pattern;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dropRequest(k);
      cpuAddr[k] = '0; cpuWdata[k] = '0; cpuBe[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_stall", 32'(cpuStall[0]), 32'd0);
    checkOutput("rst_err",   32'(busErr[0]),   32'd0);
    checkOutput("rst_rdata", cpuRdata[0],      32'd0);
    checkOutput("rst_memena",32'(memEna[0]),   32'd0);
    checkOutput("rst_memw",  32'(memW[0]),     32'd0);
    checkOutput("rst_mmio",  32'(mmioOut[0]),  32'd0);

    // DMEM write then read, no wait states.
    applyStimulus(0, 0, 1, 32'h1001_0008, 32'hCAFE_F00D, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("wr_stalls", 32'(st), 32'd2);
    checkOutput("wr_memaddr", 32'(ad), 32'd2);
    checkOutput("wr_enacyc", 32'(en), 32'd1);
    checkOutput("wr_ram", ram[0][2], 32'hCAFE_F00D);
    applyStimulus(0, 1, 0, 32'h1001_0008, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("rd_stalls", 32'(st), 32'd2);
    checkOutput("rd_data", rd, 32'hCAFE_F00D);

    // Partial byte write merges into the existing word.
    applyStimulus(0, 0, 1, 32'h1001_0008, 32'h1122_3344, 4'h5, st, rd, er, en, ad, ec);
    applyStimulus(0, 1, 0, 32'h1001_000A, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("be_merge", rd, 32'hCA22_F044);

    // Three wait states.
    applyStimulus(1, 0, 1, 32'h1001_0000, 32'hA5A5_0001, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("w3_wr_stalls", 32'(st), 32'd5);
    applyStimulus(1, 1, 0, 32'h1001_0000, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("w3_rd_stalls", 32'(st), 32'd5);
    checkOutput("w3_rd_enacyc", 32'(en), 32'd1);
    checkOutput("w3_rd_data", rd, 32'hA5A5_0001);

    // Read+write together is a write; last DMEM word is still mapped.
    applyStimulus(0, 1, 1, 32'h1001_1FFC, 32'h1234_5678, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("rw_rdata", rd, 32'd0);
    checkOutput("rw_memaddr", 32'(ad), 32'd2047);
    applyStimulus(0, 1, 0, 32'h1001_1FFC, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("last_rd", rd, 32'h1234_5678);

    // MMIO write, read back, and a write without byte 0 enabled.
    applyStimulus(0, 0, 1, 32'h1002_0004, 32'h0000_0017, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("mmio_wr_stalls", 32'(st), 32'd1);
    checkOutput("mmio_wr_ena", 32'(en), 32'd0);
    checkOutput("mmio_out", 32'(mmioOut[0]), 32'h0000_1700);
    applyStimulus(0, 1, 0, 32'h1002_0004, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("mmio_rd", rd, 32'h17);
    checkOutput("mmio_rd_stalls", 32'(st), 32'd1);
    applyStimulus(0, 0, 1, 32'h1002_0004, 32'h0000_0055, 4'hE, st, rd, er, en, ad, ec);
    checkOutput("mmio_be_e", 32'(mmioOut[0]), 32'h0000_1700);

    // Unmapped accesses.
    applyStimulus(0, 1, 0, 32'h1002_000C, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("unm_err", 32'(er), 32'd1);
    checkOutput("unm_errcyc", 32'(ec), 32'd1);
    checkOutput("unm_rdata", rd, 32'd0);
    checkOutput("unm_ena", 32'(en), 32'd0);
    checkOutput("unm_stalls", 32'(st), 32'd1);
    @(negedge clk);
    checkOutput("unm_err_after", 32'(busErr[0]), 32'd0);
    applyStimulus(0, 0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("unm0_err", 32'(er), 32'd1);
    checkOutput("unm0_ena", 32'(en), 32'd0);
    checkOutput("unm0_mmio", 32'(mmioOut[0]), 32'h0000_1700);
    applyStimulus(0, 1, 0, 32'h1001_2000, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("dmem_end_err", 32'(er), 32'd1);

    // Reset during the ACCESS cycle of a DMEM write.
    applyStimulus(0, 0, 1, 32'h1001_0014, 32'h1111_2222, 4'hF, st, rd, er, en, ad, ec);
    @(posedge clk); #1;
    cpuEna[0] = 1'b1; cpuW[0] = 1'b1; cpuR[0] = 1'b0;
    cpuAddr[0] = 32'h1001_0014; cpuWdata[0] = 32'hDEAD_BEEF; cpuBe[0] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    dropRequest(0);
    @(negedge clk);
    checkOutput("rstmid_memena", 32'(memEna[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_stall", 32'(cpuStall[0]), 32'd0);
    checkOutput("rstmid_mmio", 32'(mmioOut[0]), 32'd0);
    checkOutput("rstmid_ram", ram[0][5], 32'h1111_2222);
    applyStimulus(0, 1, 0, 32'h1001_0014, 32'h0, 4'hF, st, rd, er, en, ad, ec);
    checkOutput("rstmid_rd", rd, 32'h1111_2222);
    checkOutput("rstmid_rd_stalls", 32'(st), 32'd2);

    // Request held through DONE: completes, then restarts from IDLE.
    pattern = '0; en = 0; rd = '0;
    @(posedge clk); #1;
    cpuEna[0] = 1'b1; cpuR[0] = 1'b1; cpuW[0] = 1'b0; cpuAddr[0] = 32'h1001_0014;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pattern[5-c] = cpuStall[0];
      if (memEna[0]) en++;
      if (c == 2) rd = cpuRdata[0];
      @(posedge clk); #1;
    end
    dropRequest(0);
    checkOutput("hold_pattern", 32'(pattern), 32'(6'b110110));
    checkOutput("hold_enacyc", 32'(en), 32'd2);
    checkOutput("hold_rdata", rd, 32'h1111_2222);
    @(negedge clk);
    checkOutput("hold_idle", 32'(cpuStall[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
